// File: rtl/ntt_addr_gen.sv
// Butterfly address sequencer for an in-place radix-2 NTT (forward DIF / inverse DIT); NTT_ADDR_TWIDDLE_EN adds rd_tw_idx.
// Latency: first read pair one cycle after start is accepted, each write pair LAT en-cycles after its read.
// Backpressure: en low freezes every register, write pipeline included; start is only sampled in IDLE.
module ntt_addr_gen #(
    parameter int LOG_N   = 10,
    parameter int LAT     = 4,
    parameter int ADDR_W  = LOG_N,
    localparam int STAGE_W = (LOG_N > 2) ? $clog2(LOG_N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic               inverse,
    output logic               busy,
    output logic               rd_valid,
    output logic [ADDR_W-1:0]  rd_addr_a,
    output logic [ADDR_W-1:0]  rd_addr_b,
`ifdef NTT_ADDR_TWIDDLE_EN
    output logic [LOG_N-2:0]   rd_tw_idx,
`endif
    output logic               wr_valid,
    output logic [ADDR_W-1:0]  wr_addr_a,
    output logic [ADDR_W-1:0]  wr_addr_b,
    output logic [STAGE_W-1:0] stage,
    output logic               done
);

    localparam int JW = LOG_N - 1;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG_N - 1);
    localparam logic [3:0]         LAST_FLUSH = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, READ, FLUSH, FINISH} state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
    } pair_t;

    state_t             state, state_nx;
    logic [JW-1:0]      j, j_nx;
    logic [STAGE_W-1:0] stg, stg_nx;
    logic [3:0]         fcnt, fcnt_nx;
    logic               inv, inv_nx;

    pair_t              rd_nx, rd_q;
    pair_t              pipe [LAT];

    logic [4:0]         sh;
    logic [ADDR_W-1:0]  jx, kmask, base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            j     <= '0;
            stg   <= '0;
            fcnt  <= '0;
            inv   <= 1'b0;
        end else if (en) begin
            state <= state_nx;
            j     <= j_nx;
            stg   <= stg_nx;
            fcnt  <= fcnt_nx;
            inv   <= inv_nx;
        end
    end

    always_comb begin
        state_nx = state;
        j_nx     = j;
        stg_nx   = stg;
        fcnt_nx  = fcnt;
        inv_nx   = inv;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = READ;
                    j_nx     = '0;
                    stg_nx   = '0;
                    inv_nx   = inverse;
                end
            end
            READ: begin
                if (&j) begin
                    state_nx = FLUSH;
                    fcnt_nx  = '0;
                end else begin
                    j_nx = j + 1'b1;
                end
            end
            FLUSH: begin
                // The last write of this stage lands on the final flush cycle.
                if (fcnt == LAST_FLUSH) begin
                    if (stg == LAST_STAGE) begin
                        state_nx = FINISH;
                    end else begin
                        state_nx = READ;
                        stg_nx   = stg + 1'b1;
                        j_nx     = '0;
                    end
                end else begin
                    fcnt_nx = fcnt + 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                stg_nx   = '0;
            end
        endcase
    end

    // Pair address = j with a zero bit inserted at position log2(half); B sets that bit.
    always_comb begin
        sh       = inv_nx ? 5'(stg_nx) : 5'(LAST_STAGE - stg_nx);
        jx       = ADDR_W'(j_nx);
        kmask    = (ADDR_W'(1) << sh) - ADDR_W'(1);
        base     = ((jx >> sh) << (sh + 5'd1)) | (jx & kmask);
        rd_nx.vld = (state_nx == READ);
        rd_nx.a   = rd_nx.vld ? base : '0;
        rd_nx.b   = rd_nx.vld ? (base | (ADDR_W'(1) << sh)) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q <= '0;
        end else if (en) begin
            rd_q <= rd_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (en) begin
            pipe[0] <= rd_q;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

`ifdef NTT_ADDR_TWIDDLE_EN
    logic [LOG_N-2:0] tw_nx, tw_q;

    // Both orders shift k by LOG_N-1-log2(half).
    always_comb begin
        tw_nx = rd_nx.vld ? ((LOG_N-1)'(jx & kmask) << (5'(LAST_STAGE) - sh)) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tw_q <= '0;
        end else if (en) begin
            tw_q <= tw_nx;
        end
    end

    assign rd_tw_idx = tw_q;
`endif

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign stage     = stg;
    assign rd_valid  = rd_q.vld;
    assign rd_addr_a = rd_q.a;
    assign rd_addr_b = rd_q.b;
    assign wr_valid  = pipe[LAT-1].vld;
    assign wr_addr_a = pipe[LAT-1].a;
    assign wr_addr_b = pipe[LAT-1].b;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Scoreboard bench for ntt_addr_gen: an 8-point/LAT=4 instance checked cycle by cycle
// against a div/mod address model, plus a 1024-point/LAT=1 instance for full-size sweeps.
`timescale 1ns/1ps
module tb_ntt_addr_gen;

    localparam int LN      = 3;
    localparam int LT      = 4;
    localparam int NN      = 1 << LN;
    localparam int END_CYC = 1 + LN * (NN/2 + LT);
    localparam int LN2     = 10;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, start, start2, inverse;

    logic          busy, rd_valid, wr_valid, done;
    logic [LN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0]    stage;

    logic           busy2, rd_valid2, wr_valid2, done2;
    logic [LN2-1:0] rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;
    logic [3:0]     stage2;

`ifdef NTT_ADDR_TWIDDLE_EN
    logic [LN-2:0]  rd_tw_idx;
    logic [LN2-2:0] rd_tw_idx2;
`endif

    ntt_addr_gen #(.LOG_N(LN), .LAT(LT)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .inverse(inverse),
        .busy(busy), .rd_valid(rd_valid), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
`ifdef NTT_ADDR_TWIDDLE_EN
        .rd_tw_idx(rd_tw_idx),
`endif
        .wr_valid(wr_valid), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .stage(stage), .done(done)
    );

    ntt_addr_gen #(.LOG_N(LN2), .LAT(1)) dut_big (
        .clk(clk), .rst(rst), .en(en), .start(start2), .inverse(inverse),
        .busy(busy2), .rd_valid(rd_valid2), .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2),
`ifdef NTT_ADDR_TWIDDLE_EN
        .rd_tw_idx(rd_tw_idx2),
`endif
        .wr_valid(wr_valid2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2),
        .stage(stage2), .done(done2)
    );

    logic [17:0] obs;
    logic [47:0] obs2;
    assign obs  = {busy, rd_valid, rd_addr_a, rd_addr_b, wr_valid, wr_addr_a, wr_addr_b, stage, done};
    assign obs2 = {busy2, rd_valid2, rd_addr_a2, rd_addr_b2, wr_valid2, wr_addr_a2, wr_addr_b2, stage2, done2};

    int  n_vec = 0, n_err = 0;
    int  ecyc = 0, cyc_all = 0, start_at = 0, done_at = -1, done_cnt = 0;
    bit  mbusy = 1'b0;
    ev_t rdq[$], wrq[$];

    always @(posedge clk) cyc_all++;

    // Spec formula: half-span, k = j mod half, g = j div half.
    function automatic void model_pair(input int j, input int s, input bit inv, input int logn,
                                       output int a, output int b, output int tw);
        int half, k, g;
        half = inv ? (1 << s) : ((1 << logn) >> (s + 1));
        k  = j % half;
        g  = j / half;
        a  = g * 2 * half + k;
        b  = a + half;
        tw = inv ? (k << (logn - 1 - s)) : (k << s);
    endfunction

    task automatic push_transform(input bit inv);
        ev_t ev;
        int a, b, tw;
        for (int s = 0; s < LN; s++) begin
            for (int j = 0; j < NN/2; j++) begin
                model_pair(j, s, inv, LN, a, b, tw);
                ev.cyc = 1 + s * (NN/2 + LT) + j;
                ev.a = a; ev.b = b; ev.tw = tw; ev.st = s;
                rdq.push_back(ev);
                ev.cyc = ev.cyc + LT;
                wrq.push_back(ev);
            end
        end
    endtask

    // Scoreboard: one comparison set per en-cycle of the small instance.
    always @(negedge clk) begin : mon
        ev_t ev;
        bit  exp_done;
        if (rst && en) begin
            exp_done = mbusy && (ecyc == END_CYC);
            n_vec++;
            if (busy !== mbusy) begin
                n_err++;
                $display("FAIL busy ecyc=%0d got %b want %b", ecyc, busy, mbusy);
            end
            n_vec++;
            if (done !== exp_done) begin
                n_err++;
                $display("FAIL done ecyc=%0d got %b want %b", ecyc, done, exp_done);
            end
            if (mbusy && rdq.size() > 0 && rdq[0].cyc == ecyc) begin
                ev = rdq.pop_front();
                n_vec++;
                if (rd_valid !== 1'b1 || rd_addr_a !== ev.a[LN-1:0] || rd_addr_b !== ev.b[LN-1:0] ||
                    stage !== ev.st[1:0]) begin
                    n_err++;
                    $display("FAIL rd_pair ecyc=%0d got v=%b (%0d,%0d) st=%0d want (%0d,%0d) st=%0d",
                             ecyc, rd_valid, rd_addr_a, rd_addr_b, stage, ev.a, ev.b, ev.st);
                end
`ifdef NTT_ADDR_TWIDDLE_EN
                n_vec++;
                if (rd_tw_idx !== ev.tw[LN-2:0]) begin
                    n_err++;
                    $display("FAIL tw_idx ecyc=%0d got %0d want %0d", ecyc, rd_tw_idx, ev.tw);
                end
`endif
            end else begin
                n_vec++;
                if (rd_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rd_idle ecyc=%0d got rd_valid=%b want 0", ecyc, rd_valid);
                end
`ifdef NTT_ADDR_TWIDDLE_EN
                n_vec++;
                if (rd_tw_idx !== '0) begin
                    n_err++;
                    $display("FAIL tw_idle ecyc=%0d got %0d want 0", ecyc, rd_tw_idx);
                end
`endif
            end
            if (mbusy && wrq.size() > 0 && wrq[0].cyc == ecyc) begin
                ev = wrq.pop_front();
                n_vec++;
                if (wr_valid !== 1'b1 || wr_addr_a !== ev.a[LN-1:0] || wr_addr_b !== ev.b[LN-1:0]) begin
                    n_err++;
                    $display("FAIL wr_pair ecyc=%0d got v=%b (%0d,%0d) want (%0d,%0d)",
                             ecyc, wr_valid, wr_addr_a, wr_addr_b, ev.a, ev.b);
                end
            end else begin
                n_vec++;
                if (wr_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL wr_idle ecyc=%0d got wr_valid=%b want 0", ecyc, wr_valid);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc_all;
            end
            if (exp_done) begin
                mbusy = 1'b0;
            end else if (mbusy) begin
                ecyc++;
            end else if (start) begin
                mbusy    = 1'b1;
                ecyc     = 1;
                start_at = cyc_all;
            end
        end
    end

    task automatic do_start(input bit inv);
        @(posedge clk); #1;
        start = 1'b1; inverse = inv;
        @(posedge clk); #1;
        start = 1'b0; inverse = ~inv;
    endtask

    task automatic wait_ecyc(input int n, output bit ok);
        for (int i = 0; i < 400 && !(mbusy && ecyc == n); i++) begin
            @(posedge clk); #1;
        end
        ok = mbusy && (ecyc == n);
    endtask

    task automatic wait_idle(output bit ok);
        for (int i = 0; i < 400 && mbusy; i++) begin
            @(posedge clk); #1;
        end
        ok = !mbusy;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_small got %h want 0", obs);
        end
        n_vec++;
        if (obs2 !== '0) begin
            n_err++;
            $display("FAIL reset_big got %h want 0", obs2);
        end
`ifdef NTT_ADDR_TWIDDLE_EN
        n_vec++;
        if (rd_tw_idx !== '0 || rd_tw_idx2 !== '0) begin
            n_err++;
            $display("FAIL reset_tw got %0d/%0d want 0", rd_tw_idx, rd_tw_idx2);
        end
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_and_time(input bit inv, input int want_lat, input string name);
        bit ok;
        int d0;
        d0 = done_cnt;
        done_at = -1;
        push_transform(inv);
        do_start(inv);
        wait_idle(ok);
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (!ok || done_at - start_at != want_lat || done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL %s ok=%b done_lat=%0d dones=%0d want lat=%0d dones=1",
                     name, ok, done_at - start_at, done_cnt - d0, want_lat);
        end
    endtask

    task automatic test_forward();
        run_and_time(1'b0, END_CYC, "forward");
    endtask

    task automatic test_inverse();
        run_and_time(1'b1, END_CYC, "inverse");
    endtask

    task automatic test_stall();
        bit ok;
        logic [17:0] snap;
        done_at = -1;
        push_transform(1'b0);
        do_start(1'b0);
        wait_ecyc(NN/2 + LT + 1 + 2, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL stall_reach got ecyc=%0d want %0d", ecyc, NN/2 + LT + 3);
        end
        en   = 1'b0;
        snap = obs;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (obs !== snap) begin
                n_err++;
                $display("FAIL stall_hold got %h want %h", obs, snap);
            end
            @(posedge clk); #1;
        end
        en = 1'b1;
        wait_idle(ok);
        #1;
        n_vec++;
        if (!ok || done_at - start_at != END_CYC + 3) begin
            n_err++;
            $display("FAIL stall_lat got %0d want %0d", done_at - start_at, END_CYC + 3);
        end
    endtask

    task automatic test_restart();
        bit ok;
        int d0;
        d0 = done_cnt;
        push_transform(1'b0);
        do_start(1'b0);
        wait_ecyc(3, ok);
        start = 1'b1; inverse = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(ok);
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (!ok || done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL restart_ignored got dones=%0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        d0 = done_cnt;
        push_transform(1'b0);
        do_start(1'b0);
        wait_ecyc(10, ok);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (!ok || obs !== '0) begin
            n_err++;
            $display("FAIL reset_async got %h want 0", obs);
        end
        rdq.delete();
        wrq.delete();
        mbusy = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        n_vec++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort got dones=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_big();
        int s, jj, a, b, tw, nseen;
        bit seen [1 << LN2];
        bit pv, got_done;
        logic [LN2-1:0] pa, pb;
        s = 0; jj = 0; pv = 0; got_done = 0; pa = '0; pb = '0;
        for (int i = 0; i < (1 << LN2); i++) seen[i] = 1'b0;
        @(posedge clk); #1;
        start2 = 1'b1; inverse = 1'b0;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int c = 0; c < 8000 && !got_done; c++) begin
            @(negedge clk);
            n_vec++;
            if (wr_valid2 !== pv || (pv && (wr_addr_a2 !== pa || wr_addr_b2 !== pb))) begin
                n_err++;
                $display("FAIL big_wr st=%0d j=%0d got v=%b (%0d,%0d) want v=%b (%0d,%0d)",
                         s, jj, wr_valid2, wr_addr_a2, wr_addr_b2, pv, pa, pb);
            end
            if (rd_valid2 === 1'b1) begin
                model_pair(jj, s, 1'b0, LN2, a, b, tw);
                n_vec++;
                if (s >= LN2 || rd_addr_a2 !== a[LN2-1:0] || rd_addr_b2 !== b[LN2-1:0] || stage2 !== s[3:0]) begin
                    n_err++;
                    $display("FAIL big_rd st=%0d j=%0d got (%0d,%0d) st=%0d want (%0d,%0d)",
                             s, jj, rd_addr_a2, rd_addr_b2, stage2, a, b);
                end
`ifdef NTT_ADDR_TWIDDLE_EN
                n_vec++;
                if (rd_tw_idx2 !== tw[LN2-2:0]) begin
                    n_err++;
                    $display("FAIL big_tw st=%0d j=%0d got %0d want %0d", s, jj, rd_tw_idx2, tw);
                end
`endif
                n_vec++;
                if (rd_addr_a2 === rd_addr_b2 || seen[rd_addr_a2] || seen[rd_addr_b2]) begin
                    n_err++;
                    $display("FAIL big_unique st=%0d j=%0d got (%0d,%0d) want distinct unseen",
                             s, jj, rd_addr_a2, rd_addr_b2);
                end
                seen[rd_addr_a2] = 1'b1;
                seen[rd_addr_b2] = 1'b1;
                jj++;
                if (jj == (1 << (LN2 - 1))) begin
                    nseen = 0;
                    for (int i = 0; i < (1 << LN2); i++) begin
                        nseen += int'(seen[i]);
                        seen[i] = 1'b0;
                    end
                    n_vec++;
                    if (nseen != (1 << LN2)) begin
                        n_err++;
                        $display("FAIL big_cover st=%0d got %0d want %0d", s, nseen, 1 << LN2);
                    end
                    jj = 0;
                    s++;
                end
            end
            pv = rd_valid2;
            pa = rd_addr_a2;
            pb = rd_addr_b2;
            if (done2 === 1'b1) got_done = 1'b1;
        end
        n_vec++;
        if (!got_done || s != LN2) begin
            n_err++;
            $display("FAIL big_done got done=%b stages=%0d want 1 %0d", got_done, s, LN2);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; start = 1'b0; start2 = 1'b0; inverse = 1'b0;
        test_reset();
        test_forward();
        test_inverse();
        test_stall();
        test_restart();
        test_reset_mid();
        test_forward();
        test_big();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_addr_gen.md
Name: ntt_addr_gen

Overview:
- Parametrised butterfly address sequencer for the in-place radix-2 NTT datapath.
- Supports any power-of-two transform size N = 2^LOG_N.
- Supports forward decimation-in-frequency order and inverse decimation-in-time order.
- Each cycle it issues one butterfly read pair (A, B) to the coefficient RAM. The matching write pair follows LAT cycles later.
- It stalls globally on an enable input, flushes between stages to avoid read-after-write hazards, and reports stage and completion.

Parameters:
- LOG_N, 10, log2 of transform size; legal range 2..16.
- LAT, 4, butterfly pipeline latency from read issue to write-back; legal range 1..15.
- ADDR_W, LOG_N, coefficient RAM address width (derived; do not override).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  global advance; when low, all state, including the write pipeline, holds.
- start  input  1  begin a transform; sampled in IDLE only.
- inverse  input  1  mode; captured when start is accepted. 0 = forward, 1 = inverse.
- busy  output  1  high from start acceptance until the done pulse, inclusive.
- rd_valid  output  1  read pair valid this cycle.
- rd_addr_a  output  ADDR_W  butterfly upper-leg read address.
- rd_addr_b  output  ADDR_W  butterfly lower-leg read address.
- wr_valid  output  1  write pair valid this cycle.
- wr_addr_a  output  ADDR_W  write address A (delayed copy of rd_addr_a).
- wr_addr_b  output  ADDR_W  write address B (delayed copy of rd_addr_b).
- stage  output  max(1,clog2(LOG_N))  current stage index, 0..LOG_N-1.
- done  output  1  one-cycle pulse when the last write has been issued.

Behaviour:
- Reset:
  - All outputs are 0.
  - State goes to IDLE; the pipeline is cleared.
  - Reset asserted mid-transform aborts it, and no done pulse is produced.
- States and transitions:
  - IDLE: on start && en, capture inverse and go to READ, with stage=0 and pair counter j=0.
  - READ: one pair is issued per en cycle. j runs 0..N/2-1. After j=N/2-1, go to FLUSH.
  - FLUSH: holds LAT en-cycles with rd_valid=0. Then:
    - if stage<LOG_N-1: stage+1, j=0, go to READ;
    - otherwise go to FINISH.
  - FINISH: done=1 for one cycle, then IDLE.
- Pair addressing, with half = N>>(stage+1) for forward and half = 1<<stage for inverse:
  - k = j mod half; g = j div half.
  - rd_addr_a = g*2*half + k; rd_addr_b = rd_addr_a + half.
  - Implement with shifts and masks only; no dividers.
- Read outputs are registered. The first rd_valid appears the cycle after start is accepted.
- Write path:
  - LAT-deep shift register of {valid, addr_a, addr_b}; it advances only when en=1.
  - wr_* equals the rd_* values issued LAT en-cycles earlier.
  - The last write of a stage occurs on the final FLUSH cycle, strictly before the next stage's first read.
- en low:
  - Every register freezes and outputs hold their values.
  - A done pulse stays asserted until the next en-cycle.
- start while busy is ignored. inverse changing mid-transform has no effect.
- No address wrap: j and stage counters saturate at their terminal values and never exceed them.

Optional Feature:
- Macro NTT_ADDR_TWIDDLE_EN adds output rd_tw_idx [LOG_N-2:0], aligned with rd_addr_a.
  - Forward: rd_tw_idx = k << stage.
  - Inverse: rd_tw_idx = k << (LOG_N-1-stage).
  - It is 0 whenever rd_valid=0 and on reset.
- Without the macro, the port and its logic are absent and all other behaviour is identical.

Test Plan:
- LOG_N=3, LAT=4, forward, en=1:
  - stage0 reads (0,4),(1,5),(2,6),(3,7) on cycles 1-4;
  - stage1 reads (0,2),(1,3),(4,6),(5,7) on cycles 9-12;
  - stage2 reads (0,1),(2,3),(4,5),(6,7) on cycles 17-20;
  - last wr_valid on cycle 24, done on cycle 25, busy low on cycle 26.
- LOG_N=3, inverse:
  - stage0 pairs (0,1),(2,3),(4,5),(6,7);
  - stage1 pairs (0,2),(1,3),(4,6),(5,7);
  - stage2 pairs (0,4),(1,5),(2,6),(3,7).
  - With NTT_ADDR_TWIDDLE_EN, tw_idx = 0,0,0,0 / 0,2,0,2 / 0,1,2,3.
- Forward, en deasserted for 3 cycles during stage1 pair j=2:
  - all outputs hold;
  - the sequence resumes with (4,6), unchanged;
  - done arrives 3 cycles later than without the stall.
- start pulsed again during READ: ignored; exactly one done pulse per accepted start.
- rst asserted on cycle 10 of a transform:
  - all outputs become 0 asynchronously; no done pulse;
  - a new start then reproduces the first scenario's sequence exactly.
- LOG_N=10, LAT=1, forward:
  - 10 stages × 512 reads; every wr pair matches the rd pair from 1 cycle earlier;
  - addresses A and B are never equal;
  - each address appears exactly once per stage.
